// File: rtl/dsp_mul_rr_arbiter.sv
// dsp_mul_rr_arbiter: one pipelined unsigned multiplier shared by NUM_REQ
// requesters through a round-robin arbiter. Every product comes back
// PIPE_STAGES cycles after its grant, tagged with the requester ID.
// Optional feature macro: DSP_MUL_ARB_GRANT_CNT_EN adds the grant_cnt output,
// which holds one 16-bit saturating handshake counter per requester.
module dsp_mul_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int A_WIDTH     = 32,
  parameter int B_WIDTH     = 32,
  parameter int PIPE_STAGES = 2,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         res_valid,
  output logic [ID_W-1:0]              res_id,
  output logic [A_WIDTH+B_WIDTH-1:0]   res_p,
  output logic                         busy
`ifdef DSP_MUL_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]        grant_cnt
`endif
);

  localparam int P_W = A_WIDTH + B_WIDTH;

  logic [ID_W-1:0]    last_grant_q;
  logic [ID_W-1:0]    last_grant_d;
  logic               grant_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic [ID_W-1:0]    scan_idx_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [A_WIDTH-1:0] sel_a_s;
  logic [B_WIDTH-1:0] sel_b_s;
  logic [P_W-1:0]     prod_s;

  logic               vld_q  [PIPE_STAGES];
  logic [ID_W-1:0]    id_q   [PIPE_STAGES];
  logic [P_W-1:0]     prod_q [PIPE_STAGES];

  // Round-robin search starting just after the last granted requester.
  // Reset is folded in so that no grant is offered while it is asserted.
  always_comb begin
    grant_s     = 1'b0;
    grant_idx_s = '0;
    scan_idx_s  = '0;
    ready_s     = '0;
    if (enable && !reset) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        scan_idx_s = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
        if (!grant_s && req_valid[scan_idx_s]) begin
          grant_s     = 1'b1;
          grant_idx_s = scan_idx_s;
        end else begin
          grant_s     = grant_s;
        end
      end
    end else begin
      grant_s = 1'b0;
    end
    if (grant_s) begin
      ready_s = NUM_REQ'(1'b1) << grant_idx_s;
    end else begin
      ready_s = '0;
    end
  end

  assign req_ready = ready_s;

  // Operand mux for the granted requester, followed by the full-width product.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_s == ID_W'(i)) begin
        sel_a_s = req_a[i*A_WIDTH +: A_WIDTH];
        sel_b_s = req_b[i*B_WIDTH +: B_WIDTH];
      end else begin
        sel_a_s = sel_a_s;
      end
    end
    prod_s = P_W'(sel_a_s) * P_W'(sel_b_s);
  end

  // Next pointer value: the pointer moves only on a cycle that grants.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_s) begin
      last_grant_d = grant_idx_s;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Round-robin pointer register; after reset requester 0 has top priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // Result pipeline: the valid bits shift every cycle. A data stage loads only
  // when valid data enters it, so the last stage holds its value while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        vld_q[s]  <= 1'b0;
        id_q[s]   <= '0;
        prod_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= grant_s;
      if (grant_s) begin
        id_q[0]   <= grant_idx_s;
        prod_q[0] <= prod_s;
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          id_q[s]   <= id_q[s-1];
          prod_q[s] <= prod_q[s-1];
        end
      end
    end
  end

  assign res_valid = vld_q[PIPE_STAGES-1];
  assign res_id    = id_q[PIPE_STAGES-1];
  assign res_p     = prod_q[PIPE_STAGES-1];

  // busy reports that at least one pipeline stage holds a live operation.
  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < PIPE_STAGES; s++) begin
      busy = busy | vld_q[s];
    end
  end

`ifdef DSP_MUL_ARB_GRANT_CNT_EN
  logic [15:0] cnt_q [NUM_REQ];

  // Per-requester handshake counters that saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_s && (grant_idx_s == ID_W'(i)) && (cnt_q[i] != 16'hFFFF)) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Pack the counters into the flat output vector.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule
